// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin fifo read scheduler.
// The FSM state encoding lives here so the top module and the bench agree on it.
package fifo_rr_scheduler_pkg;

    localparam int NUM_SRC_DEF   = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int BURST_LEN_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    // Bits needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_rr_scheduler_if.sv
// Bundle of the fifo-side read controls and the downstream output stream.
// master = the scheduler, slave = the fifos plus the downstream consumer.
interface fifo_rr_scheduler_if
    import fifo_rr_scheduler_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SRC_W   = clog2_min1(NUM_SRC)
);

    logic [NUM_SRC-1:0]        src_en;
    logic [NUM_SRC-1:0]        fifo_empty;
    logic [NUM_SRC-1:0]        fifo_rd_en;
    logic [NUM_SRC*DATA_W-1:0] fifo_dout;

    // A word moves on a rising clk where out_valid && out_ready; once raised,
    // out_valid and out_data/out_src/out_last stay stable until that handshake.
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [SRC_W-1:0]  out_src;
    logic              out_last;

    modport master (
        input  src_en, fifo_empty, fifo_dout, out_ready,
        output fifo_rd_en, out_valid, out_data, out_src, out_last
    );

    modport slave (
        output src_en, fifo_empty, fifo_dout, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_src, out_last
    );

endinterface

// File: rtl/fifo_rr_scheduler_rr_pick.sv
// Combinational rotating-priority encoder: the search starts one past 'last'
// and wraps, so the most recently served requester has the lowest priority.
module fifo_rr_scheduler_rr_pick
    import fifo_rr_scheduler_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int SRC_W   = clog2_min1(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last,
    output logic               found,
    output logic [SRC_W-1:0]   idx
);

    logic [SRC_W-1:0] pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            pos = SRC_W'((int'(last) + k) % NUM_SRC);
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler draining NUM_SRC fifos into one valid/ready stream,
// granting one source for up to BURST_LEN words before priority rotates.
module fifo_rr_scheduler
    import fifo_rr_scheduler_pkg::*;
#(
    parameter int NUM_SRC   = NUM_SRC_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_rr_scheduler_if.master   bus,
    output state_t                dbg_state
);

    localparam int SRC_W = clog2_min1(NUM_SRC);
    localparam int CNT_W = clog2_min1(BURST_LEN + 1);

    state_t             state;
    logic [SRC_W-1:0]   grant;
    logic [SRC_W-1:0]   last_grant;
    logic [CNT_W-1:0]   burst_cnt;

    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;
    logic [SRC_W-1:0]   out_src_q;
    logic               out_last_q;

    logic [NUM_SRC-1:0] cand;
    logic               pick_found;
    logic [SRC_W-1:0]   pick_idx;
    logic               handshake;
    logic [DATA_W-1:0]  granted_dout;
    logic [NUM_SRC-1:0] rd_en;

    assign cand         = bus.src_en & ~bus.fifo_empty;
    assign handshake    = out_valid_q && bus.out_ready;
    assign granted_dout = bus.fifo_dout[int'(grant)*DATA_W +: DATA_W];

    fifo_rr_scheduler_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req   (cand),
        .last  (last_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Pops are issued combinationally so the fifo's registered dout is ready in FETCH.
    // A mid-burst pop needs no empty check: this block is the fifo's only reader
    // and out_last already flagged the drained case.
    always_comb begin
        rd_en = '0;
        if (!rst) begin
            if (state == S_IDLE && pick_found) begin
                rd_en[pick_idx] = 1'b1;
            end else if (state == S_OUT && handshake && !out_last_q) begin
                rd_en[grant] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= SRC_W'(NUM_SRC - 1);
            grant       <= '0;
            burst_cnt   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant     <= pick_idx;
                        burst_cnt <= CNT_W'(1);
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    out_data_q  <= granted_dout;
                    out_src_q   <= grant;
                    out_valid_q <= 1'b1;
                    // fifo_empty here already reflects the pop issued last cycle
                    out_last_q  <= (burst_cnt == CNT_W'(BURST_LEN)) || bus.fifo_empty[grant];
                    state       <= S_OUT;
                end
                S_OUT: begin
                    // valid drops after every handshake so the FETCH cycle never
                    // presents the already-accepted word a second time
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            last_grant <= grant;
                            state      <= S_IDLE;
                        end else begin
                            burst_cnt <= burst_cnt + CNT_W'(1);
                            state     <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign bus.out_last   = out_last_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: behavioural fifos with registered dout/empty,
// a per-source expected queue scoreboard and one task per scenario.
module tb_fifo_rr_scheduler;
    import fifo_rr_scheduler_pkg::*;

    localparam int NUM_SRC   = 4;
    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 4;
    localparam int SRC_W     = 2;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_rr_scheduler_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .SRC_W(SRC_W)) bus ();

    fifo_rr_scheduler #(
        .NUM_SRC   (NUM_SRC),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- fifo models ----------------
    logic [DATA_W-1:0]  src_q   [NUM_SRC][$];
    logic [DATA_W-1:0]  dout_r  [NUM_SRC];
    logic [NUM_SRC-1:0] wr_en;
    logic [DATA_W-1:0]  wr_data [NUM_SRC];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                src_q[i].delete();
                dout_r[i] <= '0;
            end
            bus.fifo_empty <= '1;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                logic [DATA_W-1:0] tmp;
                if (bus.fifo_rd_en[i] && src_q[i].size() > 0) begin
                    tmp = src_q[i].pop_front();
                    dout_r[i] <= tmp;
                end
                if (wr_en[i]) src_q[i].push_back(wr_data[i]);
                bus.fifo_empty[i] <= (src_q[i].size() == 0);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) bus.fifo_dout[i*DATA_W +: DATA_W] = dout_r[i];
    end

    // ---------------- scoreboard / monitor ----------------
    logic [DATA_W-1:0] exp_q [NUM_SRC][$];
    logic [SRC_W-1:0]  obs_src[$];
    logic              obs_last[$];
    int                obs_cyc[$];
    bit                hold_pend = 1'b0;
    logic [DATA_W-1:0] h_data;
    logic [SRC_W-1:0]  h_src;
    logic              h_last;
    logic [DATA_W-1:0] mon_exp;

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (bus.fifo_rd_en != '0) begin
                checks++;
                if (!$onehot(bus.fifo_rd_en) || (bus.fifo_rd_en & bus.fifo_empty) != '0) begin
                    errors++;
                    $display("FAIL rd_en_legal: rd_en=%b empty=%b required one-hot to a non-empty fifo",
                             bus.fifo_rd_en, bus.fifo_empty);
                end
            end
            if (hold_pend) begin
                checks++;
                if ({bus.out_valid, bus.out_data, bus.out_src, bus.out_last} !== {1'b1, h_data, h_src, h_last}) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%b d=%h s=%0d l=%b required v=1 d=%h s=%0d l=%b",
                             bus.out_valid, bus.out_data, bus.out_src, bus.out_last, h_data, h_src, h_last);
                end
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            h_data    = bus.out_data;
            h_src     = bus.out_src;
            h_last    = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q[bus.out_src].size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: src %0d data %h with no word pending", bus.out_src, bus.out_data);
                end else begin
                    mon_exp = exp_q[bus.out_src].pop_front();
                    if (bus.out_data !== mon_exp) begin
                        errors++;
                        $display("FAIL sb_data: src %0d got %h required %h", bus.out_src, bus.out_data, mon_exp);
                    end
                end
                obs_src.push_back(bus.out_src);
                obs_last.push_back(bus.out_last);
                obs_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        bus.src_en    = '0;
        bus.out_ready = 1'b0;
        wr_en       = '0;
        for (int i = 0; i < NUM_SRC; i++) exp_q[i].delete();
        tick();
        tick();
        rst = 1'b0;
        obs_src.delete();
        obs_last.delete();
        obs_cyc.delete();
    endtask

    task automatic load(input int s, input int n, input logic [DATA_W-1:0] base);
        for (int k = 0; k < n; k++) begin
            wr_en[s]   = 1'b1;
            wr_data[s] = base + DATA_W'(k);
            exp_q[s].push_back(base + DATA_W'(k));
            tick();
        end
        wr_en[s] = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (obs_src.size() < n && c < budget) begin
            tick();
            c++;
        end
        ok = (obs_src.size() >= n);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit ok;
        int c;
        state_t target;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({dbg_state, bus.out_valid, bus.out_data, bus.out_src, bus.out_last, bus.fifo_rd_en} !==
            {S_IDLE, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_values: st=%0d v=%b d=%h s=%0d l=%b rd=%b required all zero/IDLE",
                     dbg_state, bus.out_valid, bus.out_data, bus.out_src, bus.out_last, bus.fifo_rd_en);
        end
        rst = 1'b0;
        for (int p = 0; p < 2; p++) begin
            target = (p == 0) ? S_OUT : S_FETCH;
            load(2, 3, 8'h21);
            bus.out_ready = (p == 1);
            bus.src_en    = 4'b0100;
            c = 0;
            while (dbg_state != target && c < 20) begin
                tick();
                c++;
            end
            checks++;
            if (dbg_state != target) begin
                errors++;
                $display("FAIL reset_reach_state: got %0d required %0d", dbg_state, target);
            end
            #2;
            rst = 1'b1;
            for (int i = 0; i < NUM_SRC; i++) exp_q[i].delete();
            #1;
            checks++;
            if ({dbg_state, bus.out_valid, bus.out_data, bus.out_last, bus.fifo_rd_en} !==
                {S_IDLE, 1'b0, 8'h00, 1'b0, 4'b0000}) begin
                errors++;
                $display("FAIL reset_async_p%0d: st=%0d v=%b d=%h l=%b rd=%b required IDLE and zeros",
                         p, dbg_state, bus.out_valid, bus.out_data, bus.out_last, bus.fifo_rd_en);
            end
            bus.src_en    = '0;
            bus.out_ready = 1'b0;
            tick();
            tick();
            rst = 1'b0;
        end
        obs_src.delete();
        obs_last.delete();
        obs_cyc.delete();
        load(2, 1, 8'h40);
        load(0, 1, 8'h50);
        bus.out_ready = 1'b1;
        bus.src_en    = 4'b1111;
        wait_words(2, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_regrant_timeout: got %0d words required 2", obs_src.size());
        end else begin
            checks++;
            if ({obs_src[0], obs_src[1]} !== {2'd0, 2'd2}) begin
                errors++;
                $display("FAIL reset_first_grant: got %0d,%0d required 0,2", obs_src[0], obs_src[1]);
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int en_cyc;
        apply_reset();
        for (int s = 0; s < NUM_SRC; s++) load(s, 1, DATA_W'(8'h10 * (s + 1)));
        bus.out_ready = 1'b1;
        bus.src_en    = 4'b1111;
        en_cyc = cyc;
        wait_words(4, 60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_timeout: got %0d words required 4", obs_src.size());
        end else begin
            checks++;
            if (obs_cyc[0] - en_cyc != 2) begin
                errors++;
                $display("FAIL rr_latency: got %0d cycles required 2", obs_cyc[0] - en_cyc);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_src[i] !== SRC_W'(i) || obs_last[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got src=%0d last=%b required src=%0d last=1",
                             i, obs_src[i], obs_last[i], i);
                end
                if (i > 0) begin
                    checks++;
                    if (obs_cyc[i] - obs_cyc[i-1] != 3) begin
                        errors++;
                        $display("FAIL rr_gap[%0d]: got %0d cycles required 3", i, obs_cyc[i] - obs_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_burst_cap();
        bit ok;
        bit exp_last[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int exp_gap[5]  = '{2, 2, 2, 3, 2};
        apply_reset();
        load(1, 6, 8'h60);
        bus.out_ready = 1'b1;
        bus.src_en    = 4'b1111;
        wait_words(6, 80, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cap_timeout: got %0d words required 6", obs_src.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs_src[i] !== 2'd1 || obs_last[i] !== exp_last[i]) begin
                    errors++;
                    $display("FAIL cap_word[%0d]: got src=%0d last=%b required src=1 last=%b",
                             i, obs_src[i], obs_last[i], exp_last[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (obs_cyc[i] - obs_cyc[i-1] != exp_gap[i-1]) begin
                        errors++;
                        $display("FAIL cap_gap[%0d]: got %0d cycles required %0d",
                                 i, obs_cyc[i] - obs_cyc[i-1], exp_gap[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int c;
        logic [DATA_W-1:0] cap_d;
        logic [SRC_W-1:0]  cap_s;
        logic              cap_l;
        bit exp_last[3] = '{1'b0, 1'b0, 1'b1};
        apply_reset();
        load(0, 3, 8'h80);
        bus.out_ready = 1'b0;
        bus.src_en    = 4'b0001;
        c = 0;
        while (!bus.out_valid && c < 20) begin
            tick();
            c++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h80) begin
            errors++;
            $display("FAIL bp_first: got v=%b d=%h required v=1 d=80", bus.out_valid, bus.out_data);
        end
        cap_d = bus.out_data;
        cap_s = bus.out_src;
        cap_l = bus.out_last;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_src, bus.out_last, bus.fifo_rd_en} !==
                {1'b1, cap_d, cap_s, cap_l, 4'b0000}) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got v=%b d=%h s=%0d l=%b rd=%b required v=1 d=%h s=%0d l=%b rd=0000",
                         k, bus.out_valid, bus.out_data, bus.out_src, bus.out_last, bus.fifo_rd_en,
                         cap_d, cap_s, cap_l);
            end
        end
        bus.out_ready = 1'b1;
        wait_words(3, 40, ok);
        repeat (6) tick();
        checks++;
        if (!ok || obs_src.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d words required 3", obs_src.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_last[i] !== exp_last[i]) begin
                    errors++;
                    $display("FAIL bp_last[%0d]: got %b required %b", i, obs_last[i], exp_last[i]);
                end
            end
        end
    endtask

    task automatic test_mask();
        bit ok;
        int bsrc[$];
        int exp_b[4] = '{1, 3, 1, 3};
        int bad;
        apply_reset();
        for (int s = 0; s < NUM_SRC; s++) load(s, 6, DATA_W'(8'h40 * s));
        bus.out_ready = 1'b1;
        bus.src_en    = 4'b1010;
        wait_words(12, 200, ok);
        repeat (10) tick();
        checks++;
        if (!ok || obs_src.size() != 12) begin
            errors++;
            $display("FAIL mask_count: got %0d words required 12", obs_src.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 12; i++) begin
                if (obs_last[i]) bsrc.push_back(int'(obs_src[i]));
                if (obs_src[i] == 2'd0 || obs_src[i] == 2'd2) bad++;
            end
            checks++;
            if (bad != 0 || bsrc.size() != 4) begin
                errors++;
                $display("FAIL mask_sources: got %0d masked words, %0d bursts required 0 and 4", bad, bsrc.size());
            end else begin
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (bsrc[i] != exp_b[i]) begin
                        errors++;
                        $display("FAIL mask_burst[%0d]: got src %0d required %0d", i, bsrc[i], exp_b[i]);
                    end
                end
            end
        end
        checks++;
        if (exp_q[0].size() != 6 || exp_q[2].size() != 6 || dbg_state != S_IDLE) begin
            errors++;
            $display("FAIL mask_idle: got pend0=%0d pend2=%0d st=%0d required 6 6 IDLE",
                     exp_q[0].size(), exp_q[2].size(), dbg_state);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        apply_reset();
        load(3, 1, 8'hA0);
        bus.out_ready = 1'b1;
        bus.src_en    = 4'b1111;
        wait_words(1, 20, ok);
        tick();
        bus.src_en = 4'b0000;
        load(3, 1, 8'hB3);
        load(0, 1, 8'hB0);
        bus.src_en = 4'b1111;
        wait_words(3, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d words required 3", obs_src.size());
        end else begin
            checks++;
            if ({obs_src[0], obs_src[1], obs_src[2]} !== {2'd3, 2'd0, 2'd3}) begin
                errors++;
                $display("FAIL wrap_order: got %0d,%0d,%0d required 3,0,3", obs_src[0], obs_src[1], obs_src[2]);
            end
        end
    endtask

    task automatic test_random();
        int n_wr;
        int c;
        int pend;
        apply_reset();
        n_wr = 0;
        for (int t = 0; t < 600; t++) begin
            bus.src_en    = NUM_SRC'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int s = 0; s < NUM_SRC; s++) begin
                if ($urandom_range(0, 5) == 0 && exp_q[s].size() < 12) begin
                    wr_en[s]   = 1'b1;
                    wr_data[s] = DATA_W'($urandom_range(0, 255));
                    exp_q[s].push_back(wr_data[s]);
                    n_wr++;
                end else begin
                    wr_en[s] = 1'b0;
                end
            end
            tick();
        end
        wr_en         = '0;
        bus.src_en    = 4'b1111;
        bus.out_ready = 1'b1;
        c = 0;
        pend = 1;
        while (pend != 0 && c < 2000) begin
            pend = 0;
            for (int s = 0; s < NUM_SRC; s++) pend += exp_q[s].size();
            tick();
            c++;
        end
        repeat (4) tick();
        checks++;
        if (pend != 0 || obs_src.size() != n_wr) begin
            errors++;
            $display("FAIL rand_drain: got %0d words, %0d pending required %0d words, 0 pending",
                     obs_src.size(), pend, n_wr);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst           = 1'b1;
        bus.src_en    = '0;
        bus.out_ready = 1'b0;
        wr_en         = '0;
        for (int i = 0; i < NUM_SRC; i++) wr_data[i] = '0;
        test_reset();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_mask();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
